// File: rtl/reg_wb_pkg.sv
// Shared encodings for the register write-back sequencer: instruction classes,
// destination/source mux selects, FSM states and the debug view of the FSM.
package reg_wb_pkg;

   localparam int TIMER_W = 8;

   typedef enum logic [2:0] {
      OP_RTYPE = 3'b000,
      OP_IALU  = 3'b001,
      OP_LOAD  = 3'b010,
      OP_JAL   = 3'b011,
      OP_PUSH  = 3'b100,
      OP_POP   = 3'b101,
      OP_JALR  = 3'b110,
      OP_NOP   = 3'b111
   } op_class_t;

   typedef enum logic [1:0] {
      DST_RT  = 2'b00,
      DST_RD  = 2'b01,
      DST_R31 = 2'b10,
      DST_R29 = 2'b11
   } reg_dst_t;

   typedef enum logic [1:0] {
      SRC_ALU = 2'b00,
      SRC_MEM = 2'b01,
      SRC_PC4 = 2'b10,
      SRC_SP  = 2'b11
   } wb_src_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_MEM = 3'd1,
      ST_WRITE1   = 3'd2,
      ST_WRITE2   = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   // Debug view: current state plus the instruction fields captured at start.
   typedef struct packed {
      state_t      state;
      op_class_t   op;
      logic [4:0]  rt;
      logic [4:0]  rd;
   } dbg_t;

   function automatic reg_dst_t write1_dst(input op_class_t op);
      reg_dst_t d;
      case (op)
         OP_RTYPE, OP_JALR: d = DST_RD;
         OP_JAL:            d = DST_R31;
         OP_PUSH:           d = DST_R29;
         default:           d = DST_RT;
      endcase
      return d;
   endfunction

   function automatic wb_src_t write1_src(input op_class_t op);
      wb_src_t s;
      case (op)
         OP_LOAD, OP_POP:  s = SRC_MEM;
         OP_JAL, OP_JALR:  s = SRC_PC4;
         OP_PUSH:          s = SRC_SP;
         default:          s = SRC_ALU;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/reg_write_sequencer_mem_wait_timer.sv
// Saturating 8-bit cycle counter bounding how long the sequencer waits for memory.
module mem_wait_timer
   import reg_wb_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
)
(
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [TIMER_W-1:0] LIMIT = MEM_TIMEOUT[TIMER_W-1:0];

   logic [TIMER_W-1:0] r_count;

   // Clear wins over enable; the count holds at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (enable && (r_count != {TIMER_W{1'b1}})) begin
         r_count <= r_count + {{(TIMER_W-1){1'b0}}, 1'b1};
      end
   end

   assign expired = (r_count >= LIMIT);

endmodule

// File: rtl/reg_write_sequencer.sv
// Register write-back sequencer: steps the register-file write enable and mux
// selects through the write-back of one instruction, waiting on memory when needed.
module reg_write_sequencer
   import reg_wb_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
)
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic [2:0] op_class,
   input  logic [4:0] rt_addr,
   input  logic [4:0] rd_addr,
   input  logic       mem_ready,
   output logic [1:0] reg_dst_sel,
   output logic [1:0] wb_src_sel,
   output logic       reg_write,
   output logic       busy,
   output logic       done,
   output logic       mem_err,
   output dbg_t       dbg
);

   state_t     r_state;
   state_t     w_next;
   op_class_t  r_op;
   logic [4:0] r_rt;
   logic [4:0] r_rd;
   logic       r_timeout;

   logic       w_take;
   logic       w_timeout_now;
   logic       w_tmr_clear;
   logic       w_tmr_en;
   logic       w_tmr_expired;

   assign w_tmr_en = (r_state == ST_WAIT_MEM);

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (w_tmr_clear),
      .enable  (w_tmr_en),
      .expired (w_tmr_expired)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Outputs depend only on r_state and the latched class; inputs steer w_next only.
   always_comb begin
      w_next        = r_state;
      w_take        = 1'b0;
      w_timeout_now = 1'b0;
      w_tmr_clear   = 1'b0;
      reg_dst_sel   = DST_RT;
      wb_src_sel    = SRC_ALU;
      reg_write     = 1'b0;
      busy          = 1'b1;
      done          = 1'b0;
      mem_err       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               w_take = 1'b1;
               case (op_class_t'(op_class))
                  OP_LOAD, OP_POP: begin
                     w_next      = ST_WAIT_MEM;
                     w_tmr_clear = 1'b1;
                  end
                  OP_NOP:  w_next = ST_DONE;
                  default: w_next = ST_WRITE1;
               endcase
            end
         end
         ST_WAIT_MEM: begin
            if (mem_ready) begin
               w_next = ST_WRITE1;
            end else if (w_tmr_expired) begin
               w_next        = ST_DONE;
               w_timeout_now = 1'b1;
            end
         end
         ST_WRITE1: begin
            reg_write   = 1'b1;
            reg_dst_sel = write1_dst(r_op);
            wb_src_sel  = write1_src(r_op);
            w_next      = (r_op == OP_POP) ? ST_WRITE2 : ST_DONE;
         end
         ST_WRITE2: begin
            reg_write   = 1'b1;
            reg_dst_sel = DST_R29;
            wb_src_sel  = SRC_SP;
            w_next      = ST_DONE;
         end
         ST_DONE: begin
            done    = 1'b1;
            mem_err = r_timeout;
            w_next  = ST_IDLE;
         end
         default: begin
            busy   = 1'b0;
            w_next = ST_IDLE;
         end
      endcase
   end

   // r_timeout is only meaningful in DONE: it records how WAIT_MEM was left.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_op      <= OP_RTYPE;
         r_rt      <= '0;
         r_rd      <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_timeout_now;
         if (w_take) begin
            r_op <= op_class_t'(op_class);
            r_rt <= rt_addr;
            r_rd <= rd_addr;
         end
      end
   end

   assign dbg.state = r_state;
   assign dbg.op    = r_op;
   assign dbg.rt    = r_rt;
   assign dbg.rd    = r_rd;

endmodule

// File: tb/tb_reg_write_sequencer.sv
// Scoreboard bench for reg_write_sequencer: directed sequences push expected
// write/done events; a negedge monitor pops and compares each one the DUT shows.
module tb_reg_write_sequencer;
   import reg_wb_pkg::*;

   localparam int W   = 23;
   localparam int TMO = 15;

   logic       clk       = 1'b0;
   logic       reset_n   = 1'b0;
   logic       start     = 1'b0;
   logic [2:0] op_class  = 3'b000;
   logic [4:0] rt_addr   = 5'd0;
   logic [4:0] rd_addr   = 5'd0;
   logic       mem_ready = 1'b0;
   logic [1:0] reg_dst_sel;
   logic [1:0] wb_src_sel;
   logic       reg_write;
   logic       busy;
   logic       done;
   logic       mem_err;
   dbg_t       dbg;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_act;
   logic [W-1:0] mon_exp;

   reg_write_sequencer #(.MEM_TIMEOUT(TMO)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .op_class    (op_class),
      .rt_addr     (rt_addr),
      .rd_addr     (rd_addr),
      .mem_ready   (mem_ready),
      .reg_dst_sel (reg_dst_sel),
      .wb_src_sel  (wb_src_sel),
      .reg_write   (reg_write),
      .busy        (busy),
      .done        (done),
      .mem_err     (mem_err),
      .dbg         (dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Event word: {reg_write, done, mem_err, dst, src, cycle[15:0]}
   function automatic logic [W-1:0] ev(input logic w, input logic d, input logic e,
                                       input logic [1:0] dst, input logic [1:0] src,
                                       input int c);
      logic [31:0] cv;
      cv = c;
      return {w, d, e, dst, src, cv[15:0]};
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (reset_n) begin
         if (!reg_write)
            check("idle_selects", 32'({reg_dst_sel, wb_src_sel}), 32'd0);
         if (reg_write || done || mem_err) begin
            mon_act = ev(reg_write, done, mem_err, reg_dst_sel, wb_src_sel, cyc);
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_event: got %0h expected none (cycle %0d)", mon_act, cyc);
            end else begin
               mon_exp = exp_q.pop_front();
               check("event", 32'(mon_act), 32'(mon_exp));
            end
         end
      end
   end

   // ---------------- driver ----------------
   // ready_at: WAIT_MEM cycle (1-based) in which mem_ready is high, 0 = never.
   // exp_lat: hand-computed cycles from start to done.
   task automatic run_op(input logic [2:0] op, input logic [4:0] rt, input logic [4:0] rd,
                         input int ready_at, input logic [1:0] dst, input logic [1:0] src,
                         input int exp_lat, input logic exp_err);
      int s;
      @(negedge clk);
      start    = 1'b1;
      op_class = op;
      rt_addr  = rt;
      rd_addr  = rd;
      s        = cyc;
      if (op != 3'b111 && !exp_err) begin
         if (op == 3'b101) begin
            exp_q.push_back(ev(1'b1, 1'b0, 1'b0, dst, src, s + exp_lat - 2));
            exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 2'b11, 2'b11, s + exp_lat - 1));
         end else begin
            exp_q.push_back(ev(1'b1, 1'b0, 1'b0, dst, src, s + exp_lat - 1));
         end
      end
      exp_q.push_back(ev(1'b0, 1'b1, exp_err, 2'b00, 2'b00, s + exp_lat));
      for (int k = 1; k <= exp_lat + 1; k++) begin
         @(negedge clk);
         start     = 1'b0;
         mem_ready = (k == ready_at);
         if (k == 1) begin
            check("busy_after_start", 32'(busy), 32'd1);
            check("latched_rd", 32'(dbg.rd), 32'(rd));
         end
      end
      mem_ready = 1'b0;
      check("busy_after_done", 32'(busy), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int s;
      #1;
      check("rst_reg_write", 32'(reg_write), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_mem_err", 32'(mem_err), 32'd0);
      check("rst_selects", 32'({reg_dst_sel, wb_src_sel}), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      //      op      rt     rd     rdy dst    src    lat err
      run_op(3'b000, 5'd3,  5'd5,  0,  2'b01, 2'b00, 2,  1'b0); // R-type
      run_op(3'b001, 5'd4,  5'd6,  0,  2'b00, 2'b00, 2,  1'b0); // I-ALU
      run_op(3'b110, 5'd1,  5'd2,  0,  2'b01, 2'b10, 2,  1'b0); // JALR
      run_op(3'b100, 5'd8,  5'd9,  0,  2'b11, 2'b11, 2,  1'b0); // PUSH
      run_op(3'b111, 5'd0,  5'd0,  0,  2'b00, 2'b00, 1,  1'b0); // NOP
      run_op(3'b010, 5'd10, 5'd11, 1,  2'b00, 2'b01, 3,  1'b0); // LOAD, ready first cycle
      run_op(3'b101, 5'd12, 5'd13, 3,  2'b00, 2'b01, 6,  1'b0); // POP, ready 3rd cycle
      run_op(3'b010, 5'd14, 5'd15, 0,  2'b00, 2'b01, 17, 1'b1); // LOAD timeout
      run_op(3'b010, 5'd16, 5'd17, 15, 2'b00, 2'b01, 17, 1'b0); // LOAD ready before expiry
      run_op(3'b010, 5'd18, 5'd19, 16, 2'b00, 2'b01, 18, 1'b0); // LOAD ready on expiry cycle
      run_op(3'b101, 5'd20, 5'd21, 0,  2'b00, 2'b01, 17, 1'b1); // POP timeout

      // JAL with start re-pulsed in WRITE1 and DONE
      @(negedge clk);
      start = 1'b1; op_class = 3'b011; rt_addr = 5'd22; rd_addr = 5'd7;
      s = cyc;
      exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 2'b10, 2'b10, s + 1));
      exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, s + 2));
      @(negedge clk);
      op_class = 3'b000; rd_addr = 5'd30;
      check("jal_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("jal_op_kept", 32'(dbg.op), 32'(3'b011));
      check("jal_rd_kept", 32'(dbg.rd), 32'd7);
      @(negedge clk);
      start = 1'b0;
      check("jal_idle_state", 32'(dbg.state), 32'(ST_IDLE));
      @(negedge clk);
      check("jal_busy_low", 32'(busy), 32'd0);

      // POP aborted by reset during WRITE1, then NOP on first edge after reset
      @(negedge clk);
      start = 1'b1; op_class = 3'b101; rt_addr = 5'd9; rd_addr = 5'd4;
      s = cyc;
      exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 2'b00, 2'b01, s + 2));
      @(negedge clk);
      start = 1'b0; mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      check("abort_reg_write", 32'(reg_write), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_selects", 32'({reg_dst_sel, wb_src_sel}), 32'd0);
      check("abort_op_cleared", 32'(dbg.op), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      start = 1'b1; op_class = 3'b111;
      s = cyc;
      exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, s + 1));
      @(negedge clk);
      start = 1'b0;
      check("post_reset_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("post_reset_idle", 32'(busy), 32'd0);

      repeat (3) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
